// File: rtl/pci_pkg.sv
// ----------------------------------------------------------------------------
// pci_pkg
//  Shared definitions for the PCI-style bus master: bus command codes, the
//  byte-enable pattern used during data phases, and the master FSM states.
// ----------------------------------------------------------------------------
package pci_pkg;

  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;

  // C/BE# is active-low: all four byte lanes enabled.
  localparam logic [3:0] BE_ALL     = 4'b0000;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    DATA,
    MABORT,
    TURN
  } state_t;

  // Bit 0 of a PCI command distinguishes write (1) from read (0) for the
  // memory/IO command pairs this master issues.
  function automatic logic is_write_cmd(input logic [3:0] c);
    return c[0];
  endfunction

endpackage

// File: rtl/pci_bus_master.sv
// ----------------------------------------------------------------------------
// pci_bus_master
//  Initiator end of a shared PCI-style bus. On start it requests the bus,
//  waits for grant on an idle bus, drives one address phase and then a
//  1..MAX_BURST data-phase burst. Ends on last transfer, target disconnect,
//  target abort or master abort (no DEVSEL within DEVSEL_TIMEOUT clocks).
//  All bus pins are active-low.
//
// Ports
//  clk, reset (async, active-low)
//  start/cmd/addr/len   : transaction request, latched when busy=0
//  wr_data/wr_next      : write word source; wr_next marks word consumed
//  rd_data/rd_valid     : captured read word with 1-clk strobe
//  busy/done/abort      : transaction status; xfer_cnt valid with done/abort
//  req/gnt              : arbiter handshake
//  frame_o/irdy_o/ctl_oe: driven control; frame_i/irdy_i sampled bus state
//  trdy/devsel/stop     : target response
//  ad_o/ad_i/ad_oe, cbe_o/cbe_oe : multiplexed address/data and command/BE
// ----------------------------------------------------------------------------
module pci_bus_master
  import pci_pkg::*;
#(
  parameter int MAX_BURST      = 4,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  cmd,
  input  logic [31:0] addr,
  input  logic [2:0]  len,
  input  logic [31:0] wr_data,
  output logic        wr_next,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        abort,
  output logic [2:0]  xfer_cnt,
  output logic        req,
  input  logic        gnt,
  output logic        frame_o,
  output logic        irdy_o,
  output logic        ctl_oe,
  input  logic        frame_i,
  input  logic        irdy_i,
  input  logic        trdy,
  input  logic        devsel,
  input  logic        stop,
  output logic [31:0] ad_o,
  input  logic [31:0] ad_i,
  output logic        ad_oe,
  output logic [3:0]  cbe_o,
  output logic        cbe_oe
);

  localparam int TW = $clog2(DEVSEL_TIMEOUT + 1);

  state_t          state;
  state_t          state_nx;
  logic [3:0]      cmd_r;
  logic [31:0]     addr_r;
  logic [2:0]      rem;
  logic [TW-1:0]   tmo;
  logic            devsel_seen;
  logic            abort_r;
  logic            is_wr;
  logic            xfer;
  logic            accept;
  logic            fail;

  // Zero-length requests run one phase; oversize requests are clipped.
  function automatic logic [2:0] burst_len(input logic [2:0] l);
    if (l == 3'd0)            return 3'd1;
    if (l > 3'(MAX_BURST))    return 3'(MAX_BURST);
    return l;
  endfunction

  assign is_wr = is_write_cmd(cmd_r);
  // irdy_o is always asserted in DATA, so a transfer needs only the target.
  assign xfer  = (state == DATA) && !trdy && !devsel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    fail     = 1'b0;
    req      = 1'b1;
    frame_o  = 1'b1;
    irdy_o   = 1'b1;
    ctl_oe   = 1'b0;
    ad_o     = '0;
    ad_oe    = 1'b0;
    cbe_o    = BE_ALL;
    cbe_oe   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    abort    = 1'b0;
    wr_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        busy = 1'b1;
        req  = 1'b0;
        // Grant alone is not enough: the previous owner must have released
        // both FRAME# and IRDY# before we may start an address phase.
        if (!gnt && frame_i && irdy_i) state_nx = ADDR;
      end
      ADDR: begin
        busy     = 1'b1;
        frame_o  = 1'b0;
        ctl_oe   = 1'b1;
        ad_o     = addr_r;
        ad_oe    = 1'b1;
        cbe_o    = cmd_r;
        cbe_oe   = 1'b1;
        state_nx = DATA;
      end
      DATA: begin
        busy    = 1'b1;
        ctl_oe  = 1'b1;
        irdy_o  = 1'b0;
        frame_o = (rem == 3'd1);
        cbe_oe  = 1'b1;
        ad_oe   = is_wr;
        ad_o    = is_wr ? wr_data : '0;
        wr_next = xfer && is_wr;
        if (xfer) begin
          if ((rem == 3'd1) || !stop) state_nx = TURN;
        end else if (!stop && !devsel) begin
          // Disconnect without data on this phase.
          state_nx = TURN;
        end else if (!stop && devsel_seen) begin
          // Target claimed the cycle earlier and now refuses it.
          state_nx = TURN;
          fail     = 1'b1;
        end else if (devsel && !devsel_seen && (tmo == TW'(DEVSEL_TIMEOUT - 1))) begin
          state_nx = MABORT;
        end
      end
      MABORT: begin
        // Deassert FRAME# for one clock with IRDY# still low, as a normal
        // last-phase indication, before releasing the bus.
        busy     = 1'b1;
        ctl_oe   = 1'b1;
        irdy_o   = 1'b0;
        frame_o  = 1'b1;
        cbe_oe   = 1'b1;
        ad_oe    = is_wr;
        ad_o     = is_wr ? wr_data : '0;
        fail     = 1'b1;
        state_nx = TURN;
      end
      TURN: begin
        // Drive FRAME#/IRDY# high for one clock so the bus settles idle.
        ctl_oe = 1'b1;
        done   = !abort_r;
        abort  = abort_r;
        if (start) begin
          accept   = 1'b1;
          state_nx = REQ;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_r       <= '0;
      addr_r      <= '0;
      rem         <= '0;
      tmo         <= '0;
      devsel_seen <= 1'b0;
      abort_r     <= 1'b0;
      xfer_cnt    <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (accept) begin
        cmd_r    <= cmd;
        addr_r   <= addr;
        rem      <= burst_len(len);
        xfer_cnt <= '0;
        abort_r  <= 1'b0;
      end
      if (state == ADDR) begin
        tmo         <= '0;
        devsel_seen <= 1'b0;
      end
      if (state == DATA) begin
        if (!devsel)           devsel_seen <= 1'b1;
        else if (!devsel_seen) tmo         <= tmo + 1'b1;
        if (xfer) begin
          xfer_cnt <= xfer_cnt + 3'd1;
          rem      <= rem - 3'd1;
          if (!is_wr) begin
            rd_data  <= ad_i;
            rd_valid <= 1'b1;
          end
        end
      end
      if (fail) abort_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pci_bus_master.sv
module tb_pci_bus_master;
  import pci_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  cmd;
  logic [31:0] addr;
  logic [2:0]  len;
  logic [31:0] wr_data;
  logic        wr_next;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        abort;
  logic [2:0]  xfer_cnt;
  logic        req;
  logic        gnt;
  logic        frame_o;
  logic        irdy_o;
  logic        ctl_oe;
  logic        frame_i;
  logic        irdy_i;
  logic        trdy;
  logic        devsel;
  logic        stop;
  logic [31:0] ad_o;
  logic [31:0] ad_i;
  logic        ad_oe;
  logic [3:0]  cbe_o;
  logic        cbe_oe;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];

  // results of the last run_txn
  int          r_wn, r_rv, r_f0, r_f1, r_wn_first, r_wn_last, r_f1cyc, r_endcyc;
  int          r_oe_bad, r_addr_n;
  logic        r_done, r_abort;
  logic [2:0]  r_xc;
  logic        r_frm [0:7];

  pci_bus_master #(.MAX_BURST(4), .DEVSEL_TIMEOUT(5)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd), .addr(addr), .len(len),
    .wr_data(wr_data), .wr_next(wr_next), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .abort(abort), .xfer_cnt(xfer_cnt),
    .req(req), .gnt(gnt), .frame_o(frame_o), .irdy_o(irdy_o), .ctl_oe(ctl_oe),
    .frame_i(frame_i), .irdy_i(irdy_i), .trdy(trdy), .devsel(devsel), .stop(stop),
    .ad_o(ad_o), .ad_i(ad_i), .ad_oe(ad_oe), .cbe_o(cbe_o), .cbe_oe(cbe_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] wr_word(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] rd_word(input int i);
    return 32'hA5A5_0001 + 32'(i);
  endfunction

  // Issues one transaction and plays the target. Target behaviour per data
  // cycle: wait_st wait states per word; on phase stop_ph it either
  // disconnects with data (t_abort=0) or target-aborts (t_abort=1);
  // nodev never claims the cycle. Scoreboard entries are popped here.
  task automatic run_txn(input logic [3:0] c, input logic [31:0] a, input logic [2:0] l,
                         input int wait_st, input int stop_ph, input bit t_abort,
                         input bit nodev, input int budget);
    int   ph, wcnt, widx;
    bit   pend_wn, fin, in_data, rdy;
    logic [31:0] e;
    ph = 0; wcnt = 0; widx = 0; pend_wn = 0; fin = 0;
    r_wn = 0; r_rv = 0; r_f0 = 0; r_f1 = 0; r_wn_first = -1; r_wn_last = -1;
    r_f1cyc = -1; r_endcyc = -1; r_oe_bad = 0; r_addr_n = 0;
    r_done = 0; r_abort = 0; r_xc = '0;
    for (int i = 0; i < 8; i++) r_frm[i] = 1'b0;
    @(negedge clk);
    cmd = c; addr = a; len = l; wr_data = wr_word(0); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (rd_valid) begin
        r_rv++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rd_extra: got rd_data=%h want no read strobe", rd_data);
        end else begin
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            bad++;
            $display("FAIL rd_data: got %h want %h", rd_data, e);
          end
        end
      end
      if (done || abort) begin
        r_done = done; r_abort = abort; r_xc = xfer_cnt; r_endcyc = cyc; fin = 1;
        break;
      end
      if (ctl_oe && !frame_o && irdy_o) begin
        r_addr_n++;
        total++;
        if (ad_o !== a || cbe_o !== c || ad_oe !== 1'b1 || cbe_oe !== 1'b1 || req !== 1'b1) begin
          bad++;
          $display("FAIL addr_phase: got ad=%h cbe=%b oe=%b%b req=%b want ad=%h cbe=%b oe=11 req=1",
                   ad_o, cbe_o, ad_oe, cbe_oe, req, a, c);
        end
      end
      in_data = ctl_oe && !irdy_o;
      if (pend_wn) begin
        widx++;
        wr_data = wr_word(widx);
        pend_wn = 0;
      end
      if (in_data) begin
        if (frame_o) begin r_f1++; r_f1cyc = cyc; end
        else r_f0++;
        if (ad_oe !== is_write_cmd(c)) r_oe_bad++;
        if (nodev) begin
          devsel = 1'b1; trdy = 1'b1; stop = 1'b1;
        end else if (t_abort && ph == stop_ph) begin
          devsel = 1'b1; trdy = 1'b1; stop = 1'b0;
        end else begin
          devsel = 1'b0;
          rdy    = (wcnt >= wait_st);
          trdy   = !rdy;
          stop   = (rdy && ph == stop_ph) ? 1'b0 : 1'b1;
          ad_i   = rdy ? rd_word(ph) : 32'h0;
          if (rdy) begin ph++; wcnt = 0; end
          else wcnt++;
        end
      end else begin
        devsel = 1'b1; trdy = 1'b1; stop = 1'b1; wcnt = 0;
      end
      #1;
      if (wr_next) begin
        if (r_wn < 8) r_frm[r_wn] = frame_o;
        r_wn++;
        if (r_wn_first < 0) r_wn_first = cyc;
        r_wn_last = cyc;
        pend_wn = 1;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL wr_extra: got wr_next with ad_o=%h want no strobe", ad_o);
        end else begin
          e = exp_q.pop_front();
          if (ad_o !== e) begin
            bad++;
            $display("FAIL wr_data: got ad_o=%h want %h", ad_o, e);
          end
        end
      end
      @(negedge clk);
    end
    devsel = 1'b1; trdy = 1'b1; stop = 1'b1;
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL txn_timeout: got no done/abort within %0d clks want completion", budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({req, frame_o, irdy_o, ctl_oe, ad_oe, cbe_oe, busy, done, abort, wr_next, rd_valid} !== 11'b11100000000) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 11100000000",
               {req, frame_o, irdy_o, ctl_oe, ad_oe, cbe_oe, busy, done, abort, wr_next, rd_valid});
    end
    total++;
    if (rd_data !== 32'h0 || xfer_cnt !== 3'd0) begin
      bad++;
      $display("FAIL reset_data: got rd_data=%h xfer_cnt=%0d want 0 0", rd_data, xfer_cnt);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (req !== 1'b1 || ctl_oe !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got req=%b ctl_oe=%b busy=%b want 1 0 0", req, ctl_oe, busy);
    end
  endtask

  task automatic test_write_burst();
    logic [3:0] f;
    gnt = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(wr_word(i));
    run_txn(CMD_MEM_WR, 32'h0000_1000, 3'd4, 0, -1, 0, 0, 40);
    f = {r_frm[3], r_frm[2], r_frm[1], r_frm[0]};
    total++;
    if (r_addr_n !== 1) begin bad++; $display("FAIL wb_addr_phases: got %0d want 1", r_addr_n); end
    total++;
    if (r_wn !== 4 || (r_wn_last - r_wn_first) !== 3) begin
      bad++;
      $display("FAIL wb_wr_next: got count=%0d span=%0d want 4 3", r_wn, r_wn_last - r_wn_first);
    end
    total++;
    if (f !== 4'b1000) begin bad++; $display("FAIL wb_frame: got %b want 1000", f); end
    total++;
    if (r_done !== 1'b1 || r_abort !== 1'b0 || r_xc !== 3'd4) begin
      bad++;
      $display("FAIL wb_end: got done=%b abort=%b xfer=%0d want 1 0 4", r_done, r_abort, r_xc);
    end
    total++;
    if (exp_q.size() !== 0 || r_oe_bad !== 0) begin
      bad++;
      $display("FAIL wb_left: got left=%0d oe_bad=%0d want 0 0", exp_q.size(), r_oe_bad);
    end
    exp_q.delete();
  endtask

  task automatic test_read_wait();
    gnt = 1'b0;
    exp_q.push_back(32'hA5A5_0001);
    exp_q.push_back(32'hA5A5_0002);
    run_txn(CMD_MEM_RD, 32'h0000_2000, 3'd2, 2, -1, 0, 0, 40);
    total++;
    if (r_rv !== 2 || r_wn !== 0) begin
      bad++;
      $display("FAIL rw_strobes: got rd_valid=%0d wr_next=%0d want 2 0", r_rv, r_wn);
    end
    total++;
    if (r_f0 !== 3 || r_f1 !== 3) begin
      bad++;
      $display("FAIL rw_cycles: got frame0=%0d frame1=%0d want 3 3", r_f0, r_f1);
    end
    total++;
    if (r_done !== 1'b1 || r_xc !== 3'd2 || r_oe_bad !== 0 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL rw_end: got done=%b xfer=%0d oe_bad=%0d left=%0d want 1 2 0 0",
               r_done, r_xc, r_oe_bad, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_arbitration();
    bit ok;
    gnt = 1'b1; frame_i = 1'b1; irdy_i = 1'b1;
    @(negedge clk);
    cmd = CMD_MEM_WR; addr = 32'h0000_3000; len = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (req !== 1'b0 || ctl_oe !== 1'b0 || frame_o !== 1'b1) begin
        bad++;
        $display("FAIL arb_nogrant: got req=%b ctl_oe=%b frame=%b want 0 0 1", req, ctl_oe, frame_o);
      end
      @(negedge clk);
    end
    gnt = 1'b0; frame_i = 1'b0; irdy_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (req !== 1'b0 || ctl_oe !== 1'b0) begin
        bad++;
        $display("FAIL arb_busybus: got req=%b ctl_oe=%b want 0 0", req, ctl_oe);
      end
    end
    frame_i = 1'b1;
    @(negedge clk);
    total++;
    if (ctl_oe !== 1'b0) begin bad++; $display("FAIL arb_irdy_busy: got ctl_oe=%b want 0", ctl_oe); end
    irdy_i = 1'b1;
    @(negedge clk);
    total++;
    if (frame_o !== 1'b0 || ctl_oe !== 1'b1 || ad_o !== 32'h0000_3000) begin
      bad++;
      $display("FAIL arb_addr: got frame=%b ctl_oe=%b ad=%h want 0 1 00003000", frame_o, ctl_oe, ad_o);
    end
    // Grant withdrawn mid-transaction: must still complete.
    gnt = 1'b1; devsel = 1'b0; trdy = 1'b0;
    ok = 0;
    for (int i = 0; i < 6 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
    total++;
    if (!ok || xfer_cnt !== 3'd1) begin
      bad++;
      $display("FAIL arb_complete: got done_seen=%0d xfer=%0d want 1 1", ok, xfer_cnt);
    end
    devsel = 1'b1; trdy = 1'b1; gnt = 1'b0;
  endtask

  task automatic test_master_abort();
    gnt = 1'b0;
    run_txn(CMD_MEM_WR, 32'h0000_4000, 3'd4, 0, -1, 0, 1, 40);
    total++;
    if (r_f0 !== 5 || r_f1 !== 1 || (r_endcyc - r_f1cyc) !== 1) begin
      bad++;
      $display("FAIL ma_timing: got frame0=%0d frame1=%0d gap=%0d want 5 1 1", r_f0, r_f1, r_endcyc - r_f1cyc);
    end
    total++;
    if (r_abort !== 1'b1 || r_done !== 1'b0 || r_xc !== 3'd0 || r_wn !== 0) begin
      bad++;
      $display("FAIL ma_end: got abort=%b done=%b xfer=%0d wn=%0d want 1 0 0 0", r_abort, r_done, r_xc, r_wn);
    end
  endtask

  task automatic test_disconnect();
    gnt = 1'b0;
    exp_q.push_back(wr_word(0));
    exp_q.push_back(wr_word(1));
    run_txn(CMD_MEM_WR, 32'h0000_5000, 3'd4, 0, 1, 0, 0, 40);
    total++;
    if (r_done !== 1'b1 || r_abort !== 1'b0 || r_xc !== 3'd2 || r_wn !== 2 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL disc_end: got done=%b abort=%b xfer=%0d wn=%0d want 1 0 2 2", r_done, r_abort, r_xc, r_wn);
    end
    exp_q.delete();
  endtask

  task automatic test_target_abort();
    gnt = 1'b0;
    exp_q.push_back(wr_word(0));
    run_txn(CMD_MEM_WR, 32'h0000_6000, 3'd4, 0, 1, 1, 0, 40);
    total++;
    if (r_abort !== 1'b1 || r_done !== 1'b0 || r_xc !== 3'd1 || r_wn !== 1 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL tabort_end: got abort=%b done=%b xfer=%0d wn=%0d want 1 0 1 1", r_abort, r_done, r_xc, r_wn);
    end
    exp_q.delete();
  endtask

  task automatic test_len_limits();
    gnt = 1'b0;
    exp_q.push_back(rd_word(0));
    run_txn(CMD_MEM_RD, 32'h0000_7000, 3'd0, 0, -1, 0, 0, 40);
    total++;
    if (r_done !== 1'b1 || r_xc !== 3'd1 || r_rv !== 1 || r_f1 !== 1 || r_f0 !== 0) begin
      bad++;
      $display("FAIL len0: got done=%b xfer=%0d rv=%0d f1=%0d f0=%0d want 1 1 1 1 0", r_done, r_xc, r_rv, r_f1, r_f0);
    end
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(wr_word(i));
    run_txn(CMD_MEM_WR, 32'h0000_7100, 3'd7, 0, -1, 0, 0, 40);
    total++;
    if (r_done !== 1'b1 || r_xc !== 3'd4 || r_wn !== 4 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL len_clip: got done=%b xfer=%0d wn=%0d want 1 4 4", r_done, r_xc, r_wn);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    gnt = 1'b0; devsel = 1'b0; trdy = 1'b0; stop = 1'b1; ad_i = 32'h5A5A_1234;
    @(negedge clk);
    cmd = CMD_MEM_RD; addr = 32'h0000_8000; len = 3'd1; start = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || req !== 1'b0) begin
      bad++;
      $display("FAIL b2b_req1: got busy=%b req=%b want 1 0", busy, req);
    end
    addr = 32'h0000_9000;                       // start still high while busy
    @(negedge clk);
    total++;
    if (ad_o !== 32'h0000_8000 || frame_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_addr1: got ad=%h frame=%b want 00008000 0", ad_o, frame_o);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || req !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 32'h5A5A_1234) begin
      bad++;
      $display("FAIL b2b_turn: got done=%b busy=%b req=%b rv=%b rd=%h want 1 0 1 1 5a5a1234",
               done, busy, req, rd_valid, rd_data);
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (req !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_req2: got req=%b busy=%b want 0 1", req, busy);
    end
    @(negedge clk);
    total++;
    if (ad_o !== 32'h0000_9000 || frame_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_addr2: got ad=%h frame=%b want 00009000 0", ad_o, frame_o);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (done !== 1'b1 || xfer_cnt !== 3'd1) begin
      bad++;
      $display("FAIL b2b_done2: got done=%b xfer=%0d want 1 1", done, xfer_cnt);
    end
    devsel = 1'b1; trdy = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit in_data, seen;
    gnt = 1'b0; devsel = 1'b0; trdy = 1'b1; stop = 1'b1;
    @(negedge clk);
    cmd = CMD_MEM_WR; addr = 32'h0000_A000; len = 3'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_data = 0;
    for (int i = 0; i < 10 && !in_data; i++) begin
      @(negedge clk);
      in_data = ctl_oe && !irdy_o;
    end
    total++;
    if (!in_data) begin bad++; $display("FAIL rm_reach_data: got no data phase want data phase"); end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({req, frame_o, irdy_o, ctl_oe, ad_oe, cbe_oe, busy, done, abort, wr_next, rd_valid} !== 11'b11100000000) begin
      bad++;
      $display("FAIL rm_ctl: got %b want 11100000000",
               {req, frame_o, irdy_o, ctl_oe, ad_oe, cbe_oe, busy, done, abort, wr_next, rd_valid});
    end
    total++;
    if (rd_data !== 32'h0 || xfer_cnt !== 3'd0) begin
      bad++;
      $display("FAIL rm_data: got rd_data=%h xfer=%0d want 0 0", rd_data, xfer_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    devsel = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || abort || busy || !req) seen = 1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL rm_after: got activity after reset want idle"); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; cmd = 4'h0; addr = 32'h0; len = 3'd0; wr_data = 32'h0;
    gnt = 1'b1; frame_i = 1'b1; irdy_i = 1'b1; trdy = 1'b1; devsel = 1'b1; stop = 1'b1; ad_i = 32'h0;
    test_reset();
    test_write_burst();
    test_read_wait();
    test_arbitration();
    test_master_abort();
    test_disconnect();
    test_target_abort();
    test_len_limits();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
